// File: rtl/alu_mulshift_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_defs
//  Description : Shared CPU encodings used by the ALU and the multi-cycle
//                multiply/shift sequencer: ALU SELECT codes, sequencer
//                opcodes and sequencer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_defs;

    // ALU SELECT codes
    localparam logic [2:0] c_ALU_FWD = 3'b000;
    localparam logic [2:0] c_ALU_ADD = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;

    // Sequencer opcodes
    localparam logic [1:0] c_OP_MUL = 2'b00;
    localparam logic [1:0] c_OP_SLL = 2'b01;
    localparam logic [1:0] c_OP_SRL = 2'b10;
    localparam logic [1:0] c_OP_SRA = 2'b11;

    // Sequencer state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_FIN  = 2'd2;

    // MUL and SLL iterate through the shared ALU adder; right shifts do not.
    function automatic logic uses_alu(input logic [1:0] op);
        return (op == c_OP_MUL) || (op == c_OP_SLL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mulshift_sequencer_regs.sv
`default_nettype none
// ============================================================================
//  Module      : mulshift_regs
//  Description : Working registers of the multiply/shift sequencer
//                (ACC, MCAND, MPLIER, VAL, CNT) with their load and
//                per-iteration update logic.
//  Ports       : clk, rst_n        clock, async active-low reset
//                load, step        load operands / perform one iteration
//                op                opcode (incoming on load, latched on step)
//                operand1/2        operands captured on load
//                alu_result        shared ALU output, captured on MUL/SLL step
//                acc..cnt          register contents
//                val_shr           VAL shifted right by one (SRL/SRA fill)
//  Revision    : 1.0  initial release
// ============================================================================
module mulshift_regs
    import cpu_defs::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic [DATA_WIDTH-1:0] acc,
    output logic [DATA_WIDTH-1:0] mcand,
    output logic [DATA_WIDTH-1:0] mplier,
    output logic [DATA_WIDTH-1:0] val,
    output logic [2:0]            cnt,
    output logic [DATA_WIDTH-1:0] val_shr
);

    // SRA replicates the sign bit, SRL fills with zero.
    assign val_shr = {(op == c_OP_SRA) ? val[DATA_WIDTH-1] : 1'b0, val[DATA_WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            val    <= '0;
            cnt    <= 3'd0;
        end else if (load) begin
            if (op == c_OP_MUL) begin
                acc    <= '0;
                mcand  <= operand1;
                mplier <= operand2;
            end else begin
                val <= operand1;
                cnt <= operand2[2:0];
            end
        end else if (step) begin
            case (op)
                c_OP_MUL: begin
                    acc    <= alu_result;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                end
                c_OP_SLL: begin
                    val <= alu_result;
                    cnt <= cnt - 3'd1;
                end
                default: begin
                    val <= val_shr;
                    cnt <= cnt - 3'd1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_mulshift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mulshift_sequencer
//  Description : Multi-cycle sequencer running 8-bit MUL (low byte), SLL,
//                SRL and SRA. MUL/SLL borrow the shared ALU adder one
//                iteration per cycle; SRL/SRA shift internally. Stalls the
//                PC through BUSYWAIT while an op is issued or running.
//  Ports       : CLOCK, RESET      clock, async active-low reset
//                START, OPCODE     one-cycle request and op select
//                OPERAND1/2        operands (OPERAND2[2:0] = shift amount)
//                BUSYWAIT, DONE    stall and completion pulse
//                RESULT            result, held after DONE
//                ALU_OWN           ALU mux select (1 = sequencer drives ALU)
//                ALU_DATA1/2, ALU_SELECT, ALU_RESULT  shared ALU interface
//  Revision    : 1.0  initial release
// ============================================================================
module alu_mulshift_sequencer
    import cpu_defs::*;
#(
    parameter int         DATA_WIDTH  = 8,
    parameter logic [2:0] ALU_SEL_FWD = 3'b000,
    parameter logic [2:0] ALU_SEL_ADD = 3'b001
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [1:0]            OPCODE,
    input  logic [DATA_WIDTH-1:0] OPERAND1,
    input  logic [DATA_WIDTH-1:0] OPERAND2,
    output logic                  BUSYWAIT,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] RESULT,
    output logic                  ALU_OWN,
    output logic [DATA_WIDTH-1:0] ALU_DATA1,
    output logic [DATA_WIDTH-1:0] ALU_DATA2,
    output logic [2:0]            ALU_SELECT,
    input  logic [DATA_WIDTH-1:0] ALU_RESULT
);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [1:0]            r_op;
    logic [DATA_WIDTH-1:0] r_result;

    logic                  w_accept;
    logic                  w_zero_iter;
    logic                  w_run;
    logic                  w_last;
    logic [1:0]            w_regs_op;
    logic [DATA_WIDTH-1:0] w_acc;
    logic [DATA_WIDTH-1:0] w_mcand;
    logic [DATA_WIDTH-1:0] w_mplier;
    logic [DATA_WIDTH-1:0] w_val;
    logic [2:0]            w_cnt;
    logic [DATA_WIDTH-1:0] w_val_shr;

    // A request is taken in IDLE and in FIN (back-to-back); START in RUN is ignored.
    assign w_accept    = START && (r_state != c_ST_RUN);
    assign w_zero_iter = (OPCODE == c_OP_MUL) ? (OPERAND2 == '0) : (OPERAND2[2:0] == 3'd0);
    assign w_run       = (r_state == c_ST_RUN);
    // MUL ends once the multiplier has no set bits left after this step's shift.
    assign w_last      = (r_op == c_OP_MUL) ? (w_mplier[DATA_WIDTH-1:1] == '0) : (w_cnt == 3'd1);
    assign w_regs_op   = w_accept ? OPCODE : r_op;

    mulshift_regs #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regs (
        .clk        (CLOCK),
        .rst_n      (RESET),
        .load       (w_accept),
        .step       (w_run),
        .op         (w_regs_op),
        .operand1   (OPERAND1),
        .operand2   (OPERAND2),
        .alu_result (ALU_RESULT),
        .acc        (w_acc),
        .mcand      (w_mcand),
        .mplier     (w_mplier),
        .val        (w_val),
        .cnt        (w_cnt),
        .val_shr    (w_val_shr)
    );

    // State register
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_FIN: begin
                if (START) begin
                    w_next_state = w_zero_iter ? c_ST_FIN : c_ST_RUN;
                end else begin
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_RUN: begin
                if (w_last) begin
                    w_next_state = c_ST_FIN;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Latched opcode and result; RESULT only moves on entry to FIN.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_op     <= c_OP_MUL;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op <= OPCODE;
                if (w_zero_iter) begin
                    r_result <= (OPCODE == c_OP_MUL) ? '0 : OPERAND1;
                end
            end else if (w_run && w_last) begin
                r_result <= uses_alu(r_op) ? ALU_RESULT : w_val_shr;
            end
        end
    end

    assign RESULT = r_result;

    // Output logic: handshake and ALU mux
    always_comb begin
        BUSYWAIT   = w_run ? 1'b1 : START;
        DONE       = (r_state == c_ST_FIN);
        ALU_OWN    = w_run && uses_alu(r_op);
        ALU_DATA1  = '0;
        ALU_DATA2  = '0;
        ALU_SELECT = ALU_SEL_FWD;
        if (ALU_OWN) begin
            ALU_SELECT = ALU_SEL_ADD;
            if (r_op == c_OP_MUL) begin
                ALU_DATA1 = w_acc;
                ALU_DATA2 = w_mplier[0] ? w_mcand : '0;
            end else begin
                // SLL by one is VAL + VAL.
                ALU_DATA1 = w_val;
                ALU_DATA2 = w_val;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mulshift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mulshift_sequencer
//  Description : Self-checking bench for alu_mulshift_sequencer with a
//                behavioural ALU and an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_mulshift_sequencer;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       START;
    logic [1:0] OPCODE;
    logic [7:0] OPERAND1;
    logic [7:0] OPERAND2;
    logic       BUSYWAIT;
    logic       DONE;
    logic [7:0] RESULT;
    logic       ALU_OWN;
    logic [7:0] ALU_DATA1;
    logic [7:0] ALU_DATA2;
    logic [2:0] ALU_SELECT;
    logic [7:0] ALU_RESULT;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] last_result;

    always #5 CLOCK = ~CLOCK;

    // Behavioural shared ALU: FWD passes DATA1, ADD sums.
    always_comb begin
        ALU_RESULT = ALU_DATA1;
        if (ALU_SELECT == 3'b001) ALU_RESULT = ALU_DATA1 + ALU_DATA2;
    end

    alu_mulshift_sequencer #(
        .DATA_WIDTH  (8),
        .ALU_SEL_FWD (3'b000),
        .ALU_SEL_ADD (3'b001)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .START      (START),
        .OPCODE     (OPCODE),
        .OPERAND1   (OPERAND1),
        .OPERAND2   (OPERAND2),
        .BUSYWAIT   (BUSYWAIT),
        .DONE       (DONE),
        .RESULT     (RESULT),
        .ALU_OWN    (ALU_OWN),
        .ALU_DATA1  (ALU_DATA1),
        .ALU_DATA2  (ALU_DATA2),
        .ALU_SELECT (ALU_SELECT),
        .ALU_RESULT (ALU_RESULT)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: result from plain arithmetic.
    function automatic logic [7:0] model_result(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int         prod;
        logic [7:0] r;
        logic [2:0] sh;
        sh = b[2:0];
        case (op)
            2'd0: begin prod = int'(a) * int'(b); r = prod[7:0]; end
            2'd1: r = a << sh;
            2'd2: r = a >> sh;
            default: r = $unsigned($signed(a) >>> sh);
        endcase
        return r;
    endfunction

    // Reference model: iteration count.
    function automatic int model_iters(input logic [1:0] op, input logic [7:0] b);
        int n;
        n = 0;
        if (op == 2'd0) begin
            for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
        end else begin
            n = int'(b) % 8;
        end
        return n;
    endfunction

    // Called just after a falling edge: raise START and check the issue-cycle stall.
    task automatic start_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        OPCODE   = op;
        OPERAND1 = a;
        OPERAND2 = b;
        START    = 1'b1;
        #1;
        check_value("busy_issue", BUSYWAIT, 1'b1);
    endtask

    // Follows an op cycle by cycle up to and including its DONE cycle.
    task automatic track_op(input string name, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int   n;
        logic own_op;
        logic [7:0] exp_res;
        n       = model_iters(op, b);
        own_op  = (op == 2'd0) || (op == 2'd1);
        exp_res = model_result(op, a, b);
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge CLOCK);
            if (k == 1) START = 1'b0;
            #1;
            check_value({name, "/done"}, DONE, (k == n + 1));
            check_value({name, "/busy"}, BUSYWAIT, (k <= n));
            check_value({name, "/own"}, ALU_OWN, (own_op && k <= n));
            check_value({name, "/sel"}, ALU_SELECT, (own_op && k <= n) ? 3'b001 : 3'b000);
        end
        check_value({name, "/result"}, RESULT, exp_res);
        last_result = exp_res;
    endtask

    task automatic go_idle(input string name);
        @(negedge CLOCK);
        #1;
        check_value({name, "/idle_done"}, DONE, 1'b0);
        check_value({name, "/idle_busy"}, BUSYWAIT, 1'b0);
        check_value({name, "/idle_hold"}, RESULT, last_result);
        check_value({name, "/idle_d1"}, ALU_DATA1, 8'h00);
    endtask

    initial begin
        int saw_done;
        logic [1:0] rop;
        logic [7:0] ra;
        logic [7:0] rb;
        RESET       = 1'b0;
        START       = 1'b0;
        OPCODE      = 2'd0;
        OPERAND1    = 8'h00;
        OPERAND2    = 8'h00;
        last_result = 8'h00;
        #12;
        check_value("rst_result", RESULT, 8'h00);
        check_value("rst_done", DONE, 1'b0);
        check_value("rst_busy", BUSYWAIT, 1'b0);
        check_value("rst_own", ALU_OWN, 1'b0);
        check_value("rst_sel", ALU_SELECT, 3'b000);
        check_value("rst_data", {ALU_DATA1, ALU_DATA2}, 16'h0000);
        @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);

        // 13*11, then SLL 0x03 by 1 issued in the FIN cycle
        start_op(2'd0, 8'd13, 8'd11);
        track_op("mul13x11", 2'd0, 8'd13, 8'd11);
        check_value("mul13x11_val", RESULT, 8'h8F);
        start_op(2'd1, 8'h03, 8'd1);
        track_op("b2b_sll", 2'd1, 8'h03, 8'd1);
        check_value("b2b_sll_val", RESULT, 8'h06);
        go_idle("b2b");

        start_op(2'd0, 8'd20, 8'd16); track_op("mul20x16", 2'd0, 8'd20, 8'd16); go_idle("mul20x16");
        check_value("mul20x16_val", RESULT, 8'h40);
        start_op(2'd0, 8'd55, 8'd0);  track_op("mul55x0", 2'd0, 8'd55, 8'd0);  go_idle("mul55x0");
        start_op(2'd1, 8'h81, 8'd3);  track_op("sll81", 2'd1, 8'h81, 8'd3);    go_idle("sll81");
        start_op(2'd2, 8'h90, 8'd2);  track_op("srl90", 2'd2, 8'h90, 8'd2);    go_idle("srl90");
        check_value("srl90_val", RESULT, 8'h24);
        start_op(2'd3, 8'h90, 8'd2);  track_op("sra90", 2'd3, 8'h90, 8'd2);    go_idle("sra90");
        check_value("sra90_val", RESULT, 8'hE4);
        start_op(2'd1, 8'h01, 8'h0B); track_op("sll_mask", 2'd1, 8'h01, 8'h0B); go_idle("sll_mask");
        start_op(2'd1, 8'h5A, 8'h08); track_op("sll_zero", 2'd1, 8'h5A, 8'h08); go_idle("sll_zero");

        // Reset during the 3rd RUN cycle of 255*255
        start_op(2'd0, 8'd255, 8'd255);
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLOCK);
            if (k == 1) START = 1'b0;
        end
        #1;
        check_value("mid_own_before", ALU_OWN, 1'b1);
        RESET = 1'b0;
        #1;
        check_value("mid_rst_busy", BUSYWAIT, 1'b0);
        check_value("mid_rst_own", ALU_OWN, 1'b0);
        check_value("mid_rst_done", DONE, 1'b0);
        check_value("mid_rst_result", RESULT, 8'h00);
        @(negedge CLOCK);
        RESET = 1'b1;
        saw_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLOCK);
            #1;
            if (DONE) saw_done = 1;
        end
        check_value("no_done_after_rst", saw_done, 0);
        last_result = 8'h00;

        // Randomized ops, sometimes chained back-to-back from FIN
        @(negedge CLOCK);
        for (int t = 0; t < 40; t++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            start_op(rop, ra, rb);
            track_op("rand", rop, ra, rb);
            if ($urandom_range(0, 1) == 0) go_idle("rand");
        end
        go_idle("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no end of run expected summary before limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
